// File: rtl/ticket_sale_seq_if.sv
// Signal bundle between the ticket sale sequencer and its coin/keypad sources
// and ticket/change output mechanisms.
interface ticket_sale_seq_if;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic [2:0] ticket_type;
    logic [2:0] ticket_count;
    logic       sure;
    logic       nsure;
    logic       disp_ready;
    logic       change_ack;
    logic       disp_valid;
    logic [2:0] disp_type;
    logic       change_valid;
    logic [7:0] change_amount;
    logic [7:0] money_total;
    logic [7:0] price_total;
    logic       coin_reject;
    logic       err_insufficient;
    logic       sale_done;
    logic       busy;

    modport slave (
        input  coin_valid, coin_value, ticket_type, ticket_count, sure, nsure,
               disp_ready, change_ack,
        output disp_valid, disp_type, change_valid, change_amount, money_total,
               price_total, coin_reject, err_insufficient, sale_done, busy
    );

    modport master (
        output coin_valid, coin_value, ticket_type, ticket_count, sure, nsure,
               disp_ready, change_ack,
        input  disp_valid, disp_type, change_valid, change_amount, money_total,
               price_total, coin_reject, err_insufficient, sale_done, busy
    );
endinterface

// File: rtl/ticket_sale_seq.sv
// Ticket vending session sequencer: collects coins, prices the order, issues
// tickets over valid/ready, then returns change or a refund.
module ticket_sale_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    ticket_sale_seq_if.slave   bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      money_q, money_d;
    logic [7:0]      change_q, change_d;
    logic [2:0]      remaining_q, remaining_d;
    logic [2:0]      type_q, type_d;
    logic            refund_q, refund_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            coin_reject_q, coin_reject_d;
    logic            err_q, err_d;
    logic            sale_done_q, sale_done_d;

    logic [4:0]      unit;
    logic [7:0]      price;
    logic [8:0]      sum;
    logic            timeout;

    always_comb begin
        unit = 5'd30;
        case (bus.ticket_type)
            3'd0:    unit = 5'd5;
            3'd1:    unit = 5'd10;
            3'd2:    unit = 5'd20;
            default: unit = 5'd30;
        endcase
        price = {3'b0, unit} * {5'b0, bus.ticket_count};
    end

    assign sum = {1'b0, money_q} + {1'b0, bus.coin_value};
    // A coin or sure in the expiry cycle restarts the idle window instead of refunding.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !bus.coin_valid && !bus.sure;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            money_q       <= '0;
            change_q      <= '0;
            remaining_q   <= '0;
            type_q        <= '0;
            refund_q      <= 1'b0;
            cnt_q         <= '0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
            sale_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            money_q       <= money_d;
            change_q      <= change_d;
            remaining_q   <= remaining_d;
            type_q        <= type_d;
            refund_q      <= refund_d;
            cnt_q         <= cnt_d;
            coin_reject_q <= coin_reject_d;
            err_q         <= err_d;
            sale_done_q   <= sale_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        money_d       = money_q;
        change_d      = change_q;
        remaining_d   = remaining_q;
        type_d        = type_q;
        refund_d      = refund_q;
        cnt_d         = cnt_q;
        coin_reject_d = 1'b0;
        err_d         = 1'b0;
        sale_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                money_d  = '0;
                refund_d = 1'b0;
                if (bus.coin_valid) begin
                    money_d = bus.coin_value;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.nsure || timeout) begin
                    change_d      = money_q;
                    refund_d      = 1'b1;
                    coin_reject_d = bus.coin_valid;
                    state_d       = CHANGE;
                end else if (bus.sure && bus.ticket_count != 3'd0 && money_q >= price) begin
                    remaining_d   = bus.ticket_count;
                    type_d        = bus.ticket_type;
                    change_d      = money_q - price;
                    refund_d      = 1'b0;
                    cnt_d         = '0;
                    coin_reject_d = bus.coin_valid;
                    state_d       = DISPENSE;
                end else begin
                    err_d = bus.sure;
                    if (bus.coin_valid || bus.sure) cnt_d = '0;
                    else                            cnt_d = cnt_q + 1'b1;
                    if (bus.coin_valid) begin
                        if (sum[8]) coin_reject_d = 1'b1;
                        else        money_d       = sum[7:0];
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = bus.coin_valid;
                if (bus.disp_ready) begin
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) state_d = CHANGE;
                end
            end
            CHANGE: begin
                coin_reject_d = bus.coin_valid;
                if (change_q == 8'd0 || bus.change_ack) begin
                    money_d     = '0;
                    change_d    = '0;
                    sale_done_d = !refund_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.disp_valid       = (state_q == DISPENSE);
        bus.disp_type        = type_q;
        bus.change_valid     = (state_q == CHANGE) && (change_q != 8'd0);
        bus.change_amount    = change_q;
        bus.money_total      = money_q;
        bus.price_total      = price;
        bus.coin_reject      = coin_reject_q;
        bus.err_insufficient = err_q;
        bus.sale_done        = sale_done_q;
        bus.busy             = (state_q != IDLE);
    end
endmodule

// File: tb/tb_ticket_sale_seq.sv
// Directed self-checking bench for ticket_sale_seq.
module tb_ticket_sale_seq;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    ticket_sale_seq_if bus();

    ticket_sale_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [7:0] v);
        bus.coin_valid = 1'b1;
        bus.coin_value = v;
        tick();
        bus.coin_valid = 1'b0;
        bus.coin_value = '0;
    endtask

    task automatic press_sure();
        bus.sure = 1'b1;
        tick();
        bus.sure = 1'b0;
    endtask

    task automatic test_reset();
        bus.coin_valid = 0; bus.coin_value = 0; bus.ticket_type = 0; bus.ticket_count = 0;
        bus.sure = 0; bus.nsure = 0; bus.disp_ready = 0; bus.change_ack = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if ({bus.disp_valid, bus.disp_type, bus.change_valid, bus.change_amount, bus.money_total,
             bus.coin_reject, bus.err_insufficient, bus.sale_done, bus.busy} !== 26'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b money=%0d change=%0d disp_valid=%b, want all 0",
                     bus.busy, bus.money_total, bus.change_amount, bus.disp_valid);
        end
    endtask

    task automatic test_sale_with_change();
        coin(8'd20);
        coin(8'd10);
        tests_run++;
        if (bus.money_total !== 8'd30 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sale_money: got %0d busy=%b, want 30 busy=1", bus.money_total, bus.busy);
        end
        bus.ticket_type = 3'd1; bus.ticket_count = 3'd2;
        #1;
        tests_run++;
        if (bus.price_total !== 8'd20) begin
            tests_failed++;
            $display("FAIL sale_price: got %0d, want 20", bus.price_total);
        end
        press_sure();
        tests_run++;
        if (bus.disp_valid !== 1'b1 || bus.disp_type !== 3'd1) begin
            tests_failed++;
            $display("FAIL sale_disp_start: got valid=%b type=%0d, want valid=1 type=1", bus.disp_valid, bus.disp_type);
        end
        bus.disp_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.disp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sale_disp_mid: got valid=%b, want 1", bus.disp_valid);
        end
        tick();
        bus.disp_ready = 1'b0;
        tests_run++;
        if (bus.disp_valid !== 1'b0 || bus.change_valid !== 1'b1 || bus.change_amount !== 8'd10) begin
            tests_failed++;
            $display("FAIL sale_change: got disp=%b cv=%b amt=%0d, want disp=0 cv=1 amt=10",
                     bus.disp_valid, bus.change_valid, bus.change_amount);
        end
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        tests_run++;
        if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sale_done !== 1'b1 || bus.money_total !== 8'd0) begin
            tests_failed++;
            $display("FAIL sale_close: got cv=%b busy=%b done=%b money=%0d, want 0 0 1 0",
                     bus.change_valid, bus.busy, bus.sale_done, bus.money_total);
        end
        tick();
        tests_run++;
        if (bus.sale_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL sale_done_pulse: got %b, want 0", bus.sale_done);
        end
    endtask

    task automatic test_insufficient_then_exact();
        coin(8'd5);
        coin(8'd5);
        bus.ticket_type = 3'd2; bus.ticket_count = 3'd1;
        press_sure();
        tests_run++;
        if (bus.err_insufficient !== 1'b1 || bus.busy !== 1'b1 || bus.disp_valid !== 1'b0 || bus.money_total !== 8'd10) begin
            tests_failed++;
            $display("FAIL insuff_err: got err=%b busy=%b disp=%b money=%0d, want 1 1 0 10",
                     bus.err_insufficient, bus.busy, bus.disp_valid, bus.money_total);
        end
        tick();
        tests_run++;
        if (bus.err_insufficient !== 1'b0) begin
            tests_failed++;
            $display("FAIL insuff_pulse: got %b, want 0", bus.err_insufficient);
        end
        bus.ticket_count = 3'd0;
        press_sure();
        tests_run++;
        if (bus.err_insufficient !== 1'b1 || bus.disp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_count_err: got err=%b disp=%b, want 1 0", bus.err_insufficient, bus.disp_valid);
        end
        bus.ticket_count = 3'd1;
        coin(8'd10);
        tests_run++;
        if (bus.money_total !== 8'd20) begin
            tests_failed++;
            $display("FAIL exact_money: got %0d, want 20", bus.money_total);
        end
        press_sure();
        bus.disp_ready = 1'b1;
        tick();
        bus.disp_ready = 1'b0;
        tests_run++;
        if (bus.disp_valid !== 1'b0 || bus.change_valid !== 1'b0 || bus.busy !== 1'b1 || bus.change_amount !== 8'd0) begin
            tests_failed++;
            $display("FAIL exact_zero_change: got disp=%b cv=%b busy=%b amt=%0d, want 0 0 1 0",
                     bus.disp_valid, bus.change_valid, bus.busy, bus.change_amount);
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.sale_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL exact_done: got busy=%b done=%b, want 0 1", bus.busy, bus.sale_done);
        end
    endtask

    task automatic test_cancel();
        coin(8'd50);
        bus.nsure = 1'b1;
        tick();
        bus.nsure = 1'b0;
        tests_run++;
        if (bus.change_valid !== 1'b1 || bus.change_amount !== 8'd50) begin
            tests_failed++;
            $display("FAIL cancel_refund: got cv=%b amt=%0d, want 1 50", bus.change_valid, bus.change_amount);
        end
        tick();
        tests_run++;
        if (bus.change_valid !== 1'b1 || bus.change_amount !== 8'd50) begin
            tests_failed++;
            $display("FAIL cancel_hold: got cv=%b amt=%0d, want 1 50", bus.change_valid, bus.change_amount);
        end
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.sale_done !== 1'b0 || bus.change_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel_close: got busy=%b done=%b cv=%b, want 0 0 0", bus.busy, bus.sale_done, bus.change_valid);
        end
    endtask

    task automatic test_overflow_timeout();
        int unsigned waited;
        coin(8'd200);
        coin(8'd100);
        tests_run++;
        if (bus.coin_reject !== 1'b1 || bus.money_total !== 8'd200) begin
            tests_failed++;
            $display("FAIL overflow_reject: got rej=%b money=%0d, want 1 200", bus.coin_reject, bus.money_total);
        end
        coin(8'd55);
        tests_run++;
        if (bus.coin_reject !== 1'b0 || bus.money_total !== 8'd255) begin
            tests_failed++;
            $display("FAIL boundary_255: got rej=%b money=%0d, want 0 255", bus.coin_reject, bus.money_total);
        end
        // Last coin edge cleared the counter; expiry lands TO edges later.
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        tests_run++;
        if (bus.change_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: got cv=%b busy=%b, want 0 1", bus.change_valid, bus.busy);
        end
        waited = 0;
        while (bus.change_valid !== 1'b1 && waited < 5) begin
            tick();
            waited++;
        end
        tests_run++;
        if (waited !== 1 || bus.change_amount !== 8'd255) begin
            tests_failed++;
            $display("FAIL timeout_refund: got extra_cycles=%0d amt=%0d, want 1 255", waited, bus.change_amount);
        end
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.sale_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_close: got busy=%b done=%b, want 0 0", bus.busy, bus.sale_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pattern;
        int unsigned xfers;
        pattern = 5'b11001;
        xfers = 0;
        coin(8'd100);
        bus.ticket_type = 3'd0; bus.ticket_count = 3'd3;
        press_sure();
        for (int i = 0; i < 5; i++) begin
            bus.disp_ready = pattern[i];
            bus.coin_valid = (i == 1);
            bus.coin_value = 8'd10;
            if (bus.disp_valid === 1'b1 && pattern[i]) xfers++;
            tick();
            bus.coin_valid = 1'b0;
            if (i == 1) begin
                tests_run++;
                if (bus.coin_reject !== 1'b1 || bus.money_total !== 8'd100) begin
                    tests_failed++;
                    $display("FAIL disp_coin_reject: got rej=%b money=%0d, want 1 100", bus.coin_reject, bus.money_total);
                end
            end
            if (i == 3) begin
                tests_run++;
                if (bus.disp_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL disp_hold: got valid=%b, want 1", bus.disp_valid);
                end
            end
        end
        bus.disp_ready = 1'b0;
        tests_run++;
        if (xfers !== 3 || bus.disp_valid !== 1'b0 || bus.change_valid !== 1'b1 || bus.change_amount !== 8'd85) begin
            tests_failed++;
            $display("FAIL disp_end: got xfers=%0d disp=%b cv=%b amt=%0d, want 3 0 1 85",
                     xfers, bus.disp_valid, bus.change_valid, bus.change_amount);
        end
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.sale_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_close: got busy=%b done=%b, want 0 1", bus.busy, bus.sale_done);
        end
    endtask

    task automatic test_reset_mid_dispense();
        coin(8'd30);
        bus.ticket_type = 3'd3; bus.ticket_count = 3'd1;
        press_sure();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.disp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.money_total !== 8'd0 ||
            bus.change_amount !== 8'd0 || bus.disp_type !== 3'd0 || bus.change_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got disp=%b busy=%b money=%0d amt=%0d type=%0d, want all 0",
                     bus.disp_valid, bus.busy, bus.money_total, bus.change_amount, bus.disp_type);
        end
        tick();
        rst = 1'b0;
        tick();
        coin(8'd10);
        bus.ticket_type = 3'd0; bus.ticket_count = 3'd1;
        press_sure();
        bus.disp_ready = 1'b1;
        tick();
        bus.disp_ready = 1'b0;
        tests_run++;
        if (bus.change_valid !== 1'b1 || bus.change_amount !== 8'd5) begin
            tests_failed++;
            $display("FAIL post_reset_change: got cv=%b amt=%0d, want 1 5", bus.change_valid, bus.change_amount);
        end
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.sale_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_close: got busy=%b done=%b, want 0 1", bus.busy, bus.sale_done);
        end
    endtask

    initial begin
        test_reset();
        test_sale_with_change();
        test_insufficient_then_exact();
        test_cancel();
        test_overflow_timeout();
        test_back_to_back();
        test_reset_mid_dispense();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ticket_sale_seq.md
# ticket_sale_seq

Session sequencer for the ticket vending machine. It accumulates inserted coins, prices the selected ticket type and count, and on confirm issues tickets one at a time over a valid/ready handshake to the dispenser. It then returns change, or a full refund on cancel or timeout, through a change handshake. It sits between the coin acceptor and keypad inputs and the ticket/change output mechanisms.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before an automatic refund; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- coin_valid  in  1  one-cycle coin-inserted strobe
- coin_value  in  8  coin value, valid with coin_valid
- ticket_type  in  3  price class: 0→5, 1→10, 2→20, 3..7→30
- ticket_count  in  3  tickets requested, 0..7
- sure  in  1  confirm purchase
- nsure  in  1  cancel purchase
- disp_ready  in  1  dispenser can take a ticket
- change_ack  in  1  change mechanism has paid out change_amount
- disp_valid  out  1  one ticket offered to the dispenser
- disp_type  out  3  latched ticket_type, valid with disp_valid
- change_valid  out  1  change or refund request pending
- change_amount  out  8  amount to return, stable while change_valid
- money_total  out  8  credit accumulated this session
- price_total  out  8  unit price × ticket_count, from current inputs
- coin_reject  out  1  one-cycle pulse: coin not accepted, to be returned by the acceptor
- err_insufficient  out  1  one-cycle pulse: confirm refused
- sale_done  out  1  one-cycle pulse: session closed after a sale
- busy  out  1  state ≠ IDLE

## Operation
States: IDLE, COLLECT, DISPENSE, CHANGE.

Arithmetic:
- price_total = unit × count; maximum 30×7 = 210, fits 8 bits.
- Coin add uses a 9-bit sum. If the sum exceeds 255, the coin is not added and coin_reject pulses.

IDLE:
- money_total = 0.
- coin_valid adds the coin and moves to COLLECT.
- sure and nsure are ignored.

COLLECT (same-cycle priority nsure > sure > coin):
- nsure: change_amount ← money_total, refund flag set, go to CHANGE.
- sure with count ≠ 0 and money_total ≥ price_total:
  - latch remaining ← count, type, change_amount ← money_total − price_total.
  - Go to DISPENSE.
- sure with count = 0 or insufficient credit: err_insufficient pulses; stay in COLLECT.
- A coin in the same cycle as an accepted nsure/sure gets coin_reject. A coin in the same cycle as a refused sure is added normally.
- Timeout counter:
  - Cleared on entry, on any coin_valid, and on any sure.
  - When it reaches TIMEOUT_CYCLES−1, act as nsure.

DISPENSE:
- disp_valid = 1 and disp_type = latched type.
- Each cycle with disp_valid & disp_ready decrements remaining.
- On the transfer with remaining = 1, go to CHANGE.
- coin_valid gives coin_reject. sure, nsure and keypad changes are ignored.

CHANGE:
- If change_amount = 0, change_valid stays 0 and the block goes to IDLE the next cycle.
- Otherwise change_valid = 1 until the cycle change_ack is sampled high, then go to IDLE.
- sale_done pulses on the IDLE transition only if the session was a sale, not a refund.
- money_total clears on entering IDLE.
- Coins are rejected.

Reset, asynchronous:
- State IDLE; all outputs and internal registers 0.
- Reset mid-DISPENSE or mid-CHANGE abandons the session with no refund. This is accepted behaviour.

## Timing
- All inputs are sampled on posedge clk; all outputs are registered except price_total, which is combinational.
- sure accepted at edge N → disp_valid high after N, so the first ticket can transfer at edge N+1.
- Back-to-back transfers: one ticket per cycle while disp_ready is held high. disp_valid never drops mid-sale.
- Last transfer at edge M → change_valid high after M, or IDLE after M+1 if the change is 0.
- change_ack sampled at edge K → change_valid low and busy low after K.
- change_ack while change_valid = 0 is ignored.
- Pulse outputs are high for exactly one cycle after the triggering edge.
- Holding sure or nsure across multiple cycles causes no repeat action outside COLLECT.

## Test plan
- Coins 20+10, type 1, count 2, sure → disp_valid for 2 handshakes, change_valid with change_amount=10, ack → sale_done, money_total=0.
- Coins 5+5, type 2, count 1, sure → err_insufficient pulse, stay in COLLECT; coin 10, sure → 1 ticket, change 0 skips change_valid, sale_done.
- Coins 50, nsure → change_amount=50, ack → IDLE, no sale_done.
- Coin 200 then coin 100 → second coin gets coin_reject, money_total=200; wait TIMEOUT_CYCLES → refund 200.
- DISPENSE with disp_ready toggling 1,0,0,1,1 for count 3 → exactly 3 transfers; a coin mid-dispense → coin_reject.
- rst asserted mid-DISPENSE → all outputs 0 immediately, IDLE; the next session works normally.
